// File: rtl/truth_sweep_ctrl_if.sv
// Host-side bundle for the truth-table sweep sequencer: sweep control, expected
// table, unit stimulus/response and sweep results.
interface truth_sweep_ctrl_if #(
    parameter int N_IN = 4
);
    localparam int TBL_W = 2**N_IN;

    logic             start;
    logic             abort;
    logic [TBL_W-1:0] expected;
    logic             f_in;
    logic [N_IN-1:0]  abcd;
    logic             busy;
    logic             done;
    logic [TBL_W-1:0] table_out;
    logic [N_IN:0]    mism_cnt;
    logic             pass;

    modport master (
        output start, abort, expected, f_in,
        input  abcd, busy, done, table_out, mism_cnt, pass
    );

    modport slave (
        input  start, abort, expected, f_in,
        output abcd, busy, done, table_out, mism_cnt, pass
    );
endinterface

// File: rtl/truth_sweep_ctrl.sv
// Walks every input code of an N_IN-input combinational unit, samples F after a
// settle time, builds the truth table and counts mismatches against a latched expectation.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; results from the last sweep held
// ST_WAIT   | abcd applied to the unit, counting settle cycles
// ST_SAMPLE | capture F for the current code, advance or finish
// ST_DONE   | one-cycle done pulse, pass verdict registered
module truth_sweep_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    truth_sweep_ctrl_if.slave bus
);
    localparam int TBL_W = 2**N_IN;

    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0]      SETTLE_ONE  = 4'd1;
    localparam logic [N_IN-1:0] CODE_LAST   = '1;
    localparam logic [N_IN-1:0] CODE_ONE    = N_IN'(1);
    localparam logic [N_IN:0]   CNT_ONE     = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       settle;
    logic [TBL_W-1:0] exp_q;
    logic [N_IN-1:0]  abcd_q;
    logic             busy_q;
    logic             done_q;
    logic [TBL_W-1:0] table_q;
    logic [N_IN:0]    mism_q;
    logic             pass_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            settle  <= '0;
            exp_q   <= '0;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            mism_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // abort outranks start so a host can hold the block parked
                    if (bus.start && !bus.abort) begin
                        exp_q   <= bus.expected;
                        abcd_q  <= '0;
                        table_q <= '0;
                        mism_q  <= '0;
                        pass_q  <= 1'b0;
                        settle  <= '0;
                        busy_q  <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (settle == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle <= settle + SETTLE_ONE;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        table_q[abcd_q] <= bus.f_in;
                        if (bus.f_in != exp_q[abcd_q])
                            mism_q <= mism_q + CNT_ONE;
                        if (abcd_q == CODE_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            abcd_q <= abcd_q + CODE_ONE;
                            settle <= '0;
                            state  <= ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    pass_q <= (mism_q == '0);
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.abcd      = abcd_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.mism_cnt  = mism_q;
    assign bus.pass      = pass_q;
endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Bench for truth_sweep_ctrl: models the unit under test and predicts tables,
// mismatch counts and done timing from the sweep rules.
module tb_truth_sweep_ctrl;
    localparam int N_IN      = 4;
    localparam int SETTLE    = 2;
    localparam int CODES     = 2**N_IN;
    localparam int DONE_EDGE = CODES*(SETTLE+1) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    truth_sweep_ctrl_if #(.N_IN(N_IN)) bus();

    truth_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // 0: F=(A^B)&(C|~D)   1: F tied high   2: F from an arbitrary table
    int          unit_mode;
    logic [15:0] unit_tbl;

    always_comb begin
        bus.f_in = 1'b0;
        case (unit_mode)
            0:       bus.f_in = (bus.abcd[3] ^ bus.abcd[2]) & (bus.abcd[1] | ~bus.abcd[0]);
            1:       bus.f_in = 1'b1;
            default: bus.f_in = unit_tbl[bus.abcd];
        endcase
    end

    function automatic logic [15:0] ref_table(input int mode, input logic [15:0] tbl);
        logic [15:0] t;
        t = '0;
        for (int code = 0; code < CODES; code++) begin
            int a, b, c, d;
            a = (code >> 3) & 1;
            b = (code >> 2) & 1;
            c = (code >> 1) & 1;
            d = code & 1;
            if (mode == 0)      t[code] = ((a != b) && (c == 1 || d == 0));
            else if (mode == 1) t[code] = 1'b1;
            else                t[code] = tbl[code];
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, returns the edge count (after the accepting edge) at which done rose, -1 on timeout.
    task automatic run_sweep(input logic [15:0] exp_val, input bit scramble,
                             output int edges, output logic busy_after_start);
        bus.expected = exp_val;
        bus.start    = 1'b1;
        tick();
        bus.start        = 1'b0;
        busy_after_start = bus.busy;
        edges            = -1;
        for (int n = 1; n <= 200; n++) begin
            if (scramble) bus.expected = 16'($urandom);
            tick();
            if (bus.done === 1'b1) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.expected = 16'hA5A5;
        unit_mode    = 1;
        unit_tbl     = '0;
        tick();
        tick();
        checks++;
        if ({bus.abcd, bus.busy, bus.done, bus.table_out, bus.mism_cnt, bus.pass} !== '0) begin
            errors++;
            $display("FAIL reset_outputs abcd=%h busy=%b done=%b table=%h mism=%0d pass=%b required all 0",
                     bus.abcd, bus.busy, bus.done, bus.table_out, bus.mism_cnt, bus.pass);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_match();
        int e; logic b; logic [15:0] t;
        unit_mode = 0;
        t = ref_table(0, '0);
        run_sweep(16'h0DD0, 1'b0, e, b);
        checks++;
        if (b !== 1'b1) begin errors++; $display("FAIL match_busy busy=%b required 1", b); end
        checks++;
        if (e != DONE_EDGE) begin errors++; $display("FAIL match_done_edge got=%0d required=%0d", e, DONE_EDGE); end
        checks++;
        if (bus.table_out !== t) begin errors++; $display("FAIL match_table got=%h required=%h", bus.table_out, t); end
        checks++;
        if (bus.mism_cnt !== 5'd0 || bus.pass !== 1'b1) begin
            errors++; $display("FAIL match_result mism=%0d pass=%b required 0/1", bus.mism_cnt, bus.pass);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL match_busy_end busy=%b required 0", bus.busy); end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.pass !== 1'b1) begin
            errors++; $display("FAIL match_done_pulse done=%b pass=%b required 0/1", bus.done, bus.pass);
        end
    endtask

    task automatic test_mismatch();
        int e; logic b;
        unit_mode = 0;
        run_sweep(16'h0000, 1'b0, e, b);
        checks++;
        if (e != DONE_EDGE) begin errors++; $display("FAIL mism_done_edge got=%0d required=%0d", e, DONE_EDGE); end
        checks++;
        if (bus.table_out !== 16'h0DD0 || bus.mism_cnt !== 5'd6 || bus.pass !== 1'b0) begin
            errors++;
            $display("FAIL mism_result table=%h mism=%0d pass=%b required 0dd0/6/0",
                     bus.table_out, bus.mism_cnt, bus.pass);
        end
    endtask

    task automatic test_all_ones();
        int e; logic b;
        unit_mode = 1;
        run_sweep(16'h0000, 1'b0, e, b);
        checks++;
        if (e != DONE_EDGE) begin errors++; $display("FAIL ones_done_edge got=%0d required=%0d", e, DONE_EDGE); end
        checks++;
        if (bus.table_out !== 16'hFFFF || bus.mism_cnt !== 5'd16 || bus.pass !== 1'b0) begin
            errors++;
            $display("FAIL ones_result table=%h mism=%0d pass=%b required ffff/16/0",
                     bus.table_out, bus.mism_cnt, bus.pass);
        end
    endtask

    task automatic test_random();
        int e; logic b; logic [15:0] exp_val, t; int m;
        unit_mode = 2;
        for (int it = 0; it < 6; it++) begin
            unit_tbl = 16'($urandom);
            exp_val  = (it == 0) ? unit_tbl : 16'($urandom);
            t        = ref_table(2, unit_tbl);
            m        = $countones(t ^ exp_val);
            run_sweep(exp_val, it[0], e, b);
            checks++;
            if (e != DONE_EDGE) begin errors++; $display("FAIL rand%0d_done_edge got=%0d required=%0d", it, e, DONE_EDGE); end
            checks++;
            if (bus.table_out !== t) begin errors++; $display("FAIL rand%0d_table got=%h required=%h", it, bus.table_out, t); end
            checks++;
            if (bus.mism_cnt !== 5'(m) || bus.pass !== (m == 0)) begin
                errors++;
                $display("FAIL rand%0d_result mism=%0d pass=%b required %0d/%0b", it, bus.mism_cnt, bus.pass, m, (m == 0));
            end
        end
    endtask

    task automatic test_abort();
        int e; logic b; int seen;
        unit_mode    = 0;
        bus.expected = 16'h0000;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 1; n <= 15; n++) tick();
        checks++;
        if (bus.abcd !== 4'd5) begin errors++; $display("FAIL abort_pre_abcd got=%0d required=5", bus.abcd); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.abcd !== 4'd5) begin
            errors++; $display("FAIL abort_state busy=%b abcd=%0d required 0/5", bus.busy, bus.abcd);
        end
        checks++;
        if (bus.mism_cnt !== 5'd1 || bus.table_out !== 16'h0010 || bus.pass !== 1'b0) begin
            errors++;
            $display("FAIL abort_partial mism=%0d table=%h pass=%b required 1/0010/0",
                     bus.mism_cnt, bus.table_out, bus.pass);
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_quiet active_cycles=%0d required 0", seen); end
        run_sweep(16'h0DD0, 1'b0, e, b);
        checks++;
        if (e != DONE_EDGE || bus.table_out !== 16'h0DD0 || bus.mism_cnt !== 5'd0 || bus.pass !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart edge=%0d table=%h mism=%0d pass=%b required %0d/0dd0/0/1",
                     e, bus.table_out, bus.mism_cnt, bus.pass, DONE_EDGE);
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] exp_abcd; logic exp_done; int bad_step, bad_done;
        unit_mode    = 0;
        bus.expected = 16'h0DD0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        bad_step  = 0;
        bad_done  = 0;
        for (int n = 1; n <= DONE_EDGE; n++) begin
            bus.start = (n == 3 || n == 20);
            if (n == 20) bus.expected = 16'h0000;
            tick();
            bus.start = 1'b0;
            exp_abcd = 4'(((n / (SETTLE+1)) > CODES-1) ? CODES-1 : n / (SETTLE+1));
            exp_done = (n == DONE_EDGE);
            if (bus.abcd !== exp_abcd) begin
                bad_step++;
                $display("FAIL step_abcd edge=%0d got=%0d required=%0d", n, bus.abcd, exp_abcd);
            end
            if (bus.done !== exp_done) begin
                bad_done++;
                $display("FAIL step_done edge=%0d got=%b required=%b", n, bus.done, exp_done);
            end
        end
        checks++;
        if (bad_step != 0) errors++;
        checks++;
        if (bad_done != 0) errors++;
        checks++;
        if (bus.mism_cnt !== 5'd0 || bus.pass !== 1'b1) begin
            errors++; $display("FAIL start_ignored_latch mism=%0d pass=%b required 0/1", bus.mism_cnt, bus.pass);
        end
    endtask

    task automatic test_rst_mid_sweep();
        int e; logic b; int seen;
        unit_mode    = 0;
        bus.expected = 16'h0DD0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 1; n <= 27; n++) tick();
        checks++;
        if (bus.abcd !== 4'd9 || bus.table_out !== 16'h01D0) begin
            errors++; $display("FAIL rst_pre abcd=%0d table=%h required 9/01d0", bus.abcd, bus.table_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.abcd, bus.busy, bus.done, bus.table_out, bus.mism_cnt, bus.pass} !== '0) begin
            errors++;
            $display("FAIL rst_async abcd=%h busy=%b done=%b table=%h mism=%0d pass=%b required all 0",
                     bus.abcd, bus.busy, bus.done, bus.table_out, bus.mism_cnt, bus.pass);
        end
        tick();
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_quiet active_cycles=%0d required 0", seen); end
        run_sweep(16'h0DD0, 1'b0, e, b);
        checks++;
        if (e != DONE_EDGE || bus.table_out !== 16'h0DD0 || bus.pass !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart edge=%0d table=%h pass=%b required %0d/0dd0/1",
                     e, bus.table_out, bus.pass, DONE_EDGE);
        end
    endtask

    task automatic test_back_to_back();
        int e; logic b;
        unit_mode = 1;
        run_sweep(16'hFFFF, 1'b0, e, b);
        checks++;
        if (e != DONE_EDGE || bus.pass !== 1'b1) begin
            errors++; $display("FAIL b2b_first edge=%0d pass=%b required %0d/1", e, bus.pass, DONE_EDGE);
        end
        unit_mode = 0;
        run_sweep(16'hFFFF, 1'b0, e, b);
        checks++;
        if (b !== 1'b1 || e != DONE_EDGE || bus.table_out !== 16'h0DD0 || bus.mism_cnt !== 5'd10 || bus.pass !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second busy=%b edge=%0d table=%h mism=%0d pass=%b required 1/%0d/0dd0/10/0",
                     b, e, bus.table_out, bus.mism_cnt, bus.pass, DONE_EDGE);
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_all_ones();
        test_random();
        test_abort();
        test_start_ignored();
        test_rst_mid_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
